// File: rtl/fb_window_engine.sv
// rtl/fb_window_engine.sv - scaled framebuffer window, pipelined RAM read, write/clear arbitration.
// Optional double buffering is enabled by defining FB_DOUBLE_BUFFER_EN.
module fb_window_engine #(
  parameter int SRC_W      = 240,
  parameter int SRC_H      = 160,
  parameter int SCALE_LOG2 = 1,
  parameter int X0         = 80,
  parameter int Y0         = 80,
  parameter int PIX_W      = 24,
  parameter int ADDR_W     = 19,
  parameter int RD_LAT     = 1,
  parameter logic [PIX_W-1:0] BORDER = 24'h000000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  pix_out,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ready,
  input  logic              clr_start,
  input  logic [PIX_W-1:0]  clr_color,
  output logic              busy,
  output logic              clr_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic              swap_req,
  output logic              front_bank
);

  localparam int NPIX_I = SRC_W * SRC_H;
  localparam logic [ADDR_W-1:0] NPIX = ADDR_W'(NPIX_I);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX_I - 1);
  localparam logic [31:0] X_LO = 32'(X0);
  localparam logic [31:0] X_HI = 32'(X0 + (SRC_W << SCALE_LOG2));
  localparam logic [31:0] Y_LO = 32'(Y0);
  localparam logic [31:0] Y_HI = 32'(Y0 + (SRC_H << SCALE_LOG2));

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt;
  logic [PIX_W-1:0]    clr_col;
  logic [31:0]         x_full, y_full, dx, dy;
  logic                in_win, in_q;
  logic [RD_LAT-1:0]   flag_dly;
  logic [ADDR_W-1:0]   rd_base, wr_base;

`ifdef FB_DOUBLE_BUFFER_EN
  logic swap_pend, front_q;

  // Swap only at the top-left of the frame so a frame is never torn.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      swap_pend <= 1'b0;
      front_q   <= 1'b0;
    end else if (swap_pend && !busy && DrawX == 10'd0 && DrawY == 10'd0) begin
      front_q   <= ~front_q;
      swap_pend <= 1'b0;
    end else if (swap_req) begin
      swap_pend <= 1'b1;
    end
  end

  assign front_bank = front_q;
  assign rd_base    = front_q ? NPIX : '0;
  assign wr_base    = front_q ? '0 : NPIX;
`else
  logic unused_swap;
  assign unused_swap = swap_req;
  assign front_bank  = 1'b0;
  assign rd_base     = '0;
  assign wr_base     = '0;
`endif

  always_comb begin
    x_full = {22'b0, DrawX};
    y_full = {22'b0, DrawY};
    dx     = x_full - X_LO;
    dy     = y_full - Y_LO;
    in_win = (x_full >= X_LO) && (x_full < X_HI) && (y_full >= Y_LO) && (y_full < Y_HI);
  end

  // Read path: address/flag stage, RD_LAT flag delay matching the RAM, output stage.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_addr  <= '0;
      in_q     <= 1'b0;
      flag_dly <= '0;
      pix_out  <= BORDER;
    end else begin
      in_q    <= in_win;
      rd_addr <= in_win ? rd_base + ADDR_W'((dy >> SCALE_LOG2) * 32'(SRC_W) + (dx >> SCALE_LOG2))
                        : '0;
      flag_dly[0] <= in_q;
      for (int i = 1; i < RD_LAT; i++) flag_dly[i] <= flag_dly[i-1];
      pix_out <= flag_dly[RD_LAT-1] ? rd_data : BORDER;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_ready = 1'b0;
    busy     = 1'b0;
    clr_done = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (clr_start) state_nx = CLEAR;
      end
      CLEAR: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        clr_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A write accepted alongside clr_start lands first; the clear's writes follow from the next cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt       <= '0;
      clr_col   <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req && wr_addr < NPIX) begin
            mem_we    <= 1'b1;
            mem_waddr <= wr_base + wr_addr;
            mem_wdata <= wr_data;
          end
          if (clr_start) begin
            clr_col <= clr_color;
            cnt     <= '0;
          end
        end
        CLEAR: begin
          mem_we    <= 1'b1;
          mem_waddr <= wr_base + cnt;
          mem_wdata <= clr_col;
          cnt       <= cnt + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_window_engine.sv
// tb/tb_fb_window_engine.sv - scoreboard bench for fb_window_engine.
module tb_fb_window_engine;

  localparam int N = 38400;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int WOFF = N;
`else
  localparam int WOFF = 0;
`endif

  logic        Clk, Reset;
  logic [9:0]  DrawX, DrawY;
  logic [18:0] rd_addr, wr_addr, mem_waddr;
  logic [23:0] rd_data, pix_out, wr_data, clr_color, mem_wdata;
  logic        wr_req, wr_ready, clr_start, busy, clr_done, mem_we, swap_req, front_bank;

  fb_window_engine dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .rd_addr(rd_addr), .rd_data(rd_data), .pix_out(pix_out),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_color(clr_color), .busy(busy), .clr_done(clr_done),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .swap_req(swap_req), .front_bank(front_bank)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // RAM model: one-cycle read returning a tag derived from the address.
  always @(posedge Clk) rd_data <= 24'hA00000 | 24'(rd_addr);

  int cyc = 0;
  always @(posedge Clk) cyc++;

  int n_cmp = 0, n_bad = 0;
  int busy_cnt = 0, done_cnt = 0, rdy_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct { int due; logic [31:0] val; } tq_t;
  typedef struct { logic [18:0] a; logic [23:0] d; } wq_t;
  tq_t addr_q[$];
  tq_t pix_q[$];
  wq_t wr_q[$];

  always @(negedge Clk) begin
    tq_t e;
    wq_t w;
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      e = addr_q.pop_front();
      chk("rd_addr", 32'(rd_addr), e.val);
    end
    while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      e = pix_q.pop_front();
      chk("pix_out", 32'(pix_out), e.val);
    end
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        chk("spurious_write", 32'(mem_waddr), 32'hFFFFFFFF);
      end else begin
        w = wr_q.pop_front();
        chk("mem_waddr", 32'(mem_waddr), 32'(w.a));
        chk("mem_wdata", 32'(mem_wdata), 32'(w.d));
      end
    end
    if (busy) busy_cnt++;
    if (busy && wr_ready) rdy_bad++;
    if (clr_done) done_cnt++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_px(input int x, input int y, input logic inw, input int a);
    DrawX = 10'(x);
    DrawY = 10'(y);
    addr_q.push_back('{cyc + 1, inw ? 32'(a) : 32'd0});
    pix_q.push_back('{cyc + 3, inw ? (32'hA00000 | 32'(a)) : 32'd0});
    tick();
  endtask

  task automatic push_clear(input int count, input logic [23:0] col);
    for (int i = 0; i < count; i++) wr_q.push_back('{19'(i + WOFF), col});
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_cnt == 0 && t < 40000) begin
      tick();
      t++;
    end
    chk(name, 32'(done_cnt != 0), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    Reset = 1'b1; DrawX = '0; DrawY = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_color = '0; swap_req = 1'b0;
    repeat (3) tick();
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_pix_out", 32'(pix_out), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_waddr", 32'(mem_waddr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clr_done", 32'(clr_done), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_front_bank", 32'(front_bank), 0);
    Reset = 1'b0;
    tick();

    // Back-to-back coordinates, one per cycle.
    drive_px(80, 80, 1'b1, 0);
    drive_px(559, 399, 1'b1, 38399);
    drive_px(79, 80, 1'b0, 0);
    drive_px(80, 400, 1'b0, 0);
    drive_px(81, 81, 1'b1, 0);
    drive_px(82, 84, 1'b1, 481);
    drive_px(560, 80, 1'b0, 0);
    drive_px(300, 200, 1'b1, 14510);
    drive_px(80, 79, 1'b0, 0);
    DrawX = '0; DrawY = '0;
    repeat (4) tick();
    chk("rd_drained", 32'(addr_q.size() + pix_q.size()), 0);

    wr_req = 1'b1; wr_addr = 19'd38399; wr_data = 24'h123456;
    wr_q.push_back('{19'(38399 + WOFF), 24'h123456});
    tick();
    wr_req = 1'b0;
    tick();

    wr_req = 1'b1; wr_addr = 19'd38400; wr_data = 24'hABCDEF;
    chk("oob_wr_ready", 32'(wr_ready), 1);
    tick();
    wr_req = 1'b0;
    chk("oob_mem_we", 32'(mem_we), 0);
    tick();

    // Write and clear requested together: the write lands first.
    wr_req = 1'b1; wr_addr = 19'd5; wr_data = 24'h00FF00;
    clr_start = 1'b1; clr_color = 24'hFF0000;
    wr_q.push_back('{19'(5 + WOFF), 24'h00FF00});
    push_clear(N, 24'hFF0000);
    busy_cnt = 0; done_cnt = 0; rdy_bad = 0;
    tick();
    clr_color = 24'h0000FF; wr_addr = 19'd7;
    repeat (5) tick();
    wr_req = 1'b0; clr_start = 1'b0;
    wait_done("clr1_timeout");
    chk("clr1_busy_cycles", 32'(busy_cnt), 32'(N));
    chk("clr1_done_pulses", 32'(done_cnt), 1);
    chk("clr1_wr_ready_low", 32'(rdy_bad), 0);
    chk("clr1_writes_left", 32'(wr_q.size()), 0);

    // Reset 100 cycles into a clear aborts it silently.
    clr_color = 24'h0000FF; clr_start = 1'b1;
    push_clear(99, 24'h0000FF);
    done_cnt = 0;
    tick();
    clr_start = 1'b0;
    repeat (99) tick();
    Reset = 1'b1;
    tick();
    chk("abort_mem_we", 32'(mem_we), 0);
    chk("abort_busy", 32'(busy), 0);
    Reset = 1'b0;
    repeat (3) tick();
    chk("abort_writes_left", 32'(wr_q.size()), 0);
    chk("abort_no_done", 32'(done_cnt), 0);

    clr_color = 24'h0000FF; clr_start = 1'b1;
    push_clear(N, 24'h0000FF);
    busy_cnt = 0; done_cnt = 0;
    tick();
    clr_start = 1'b0;
    wait_done("clr2_timeout");
    chk("clr2_busy_cycles", 32'(busy_cnt), 32'(N));
    chk("clr2_done_pulses", 32'(done_cnt), 1);
    chk("clr2_writes_left", 32'(wr_q.size()), 0);

`ifdef FB_DOUBLE_BUFFER_EN
    DrawX = 10'd100; DrawY = 10'd100; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (3) tick();
    chk("swap_held_midframe", 32'(front_bank), 0);
    DrawX = 10'd0; DrawY = 10'd0;
    tick();
    chk("swap_at_origin", 32'(front_bank), 1);
    DrawX = 10'd100;
    tick();
    wr_req = 1'b1; wr_addr = 19'd0; wr_data = 24'h000001;
    wr_q.push_back('{19'd0, 24'h000001});
    tick();
    wr_req = 1'b0;
    repeat (2) tick();
    chk("db_writes_left", 32'(wr_q.size()), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
